// File: rtl/ram_access_pkg.sv
// Shared types and constants for the RAM access sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_access_pkg;

  localparam int RAM_DEPTH = 32;
  localparam int LAT_STORE = 4;
  localparam int LAT_LOAD  = 2;
  localparam int LAT_ERR   = 1;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_ADDR,
    RESP
  } state_t;

endpackage

// File: rtl/ram_addr_chk.sv
// Byte address -> RAM word index plus range/alignment error flags.
// Latency: combinational.
// Backpressure: none. Alignment checking exists only when MEM_ALIGN_CHK_EN is defined.
module ram_addr_chk #(
  parameter int ADDR_W = 5
) (
  input  logic [31:0]       addr_i,
  output logic [ADDR_W-1:0] word_idx_o,
  output logic              range_err_o,
  output logic              align_err_o
);

`ifdef MEM_ALIGN_CHK_EN
  localparam logic ALIGN_CHK = 1'b1;
`else
  // Low address bits are dropped; the access is word-truncated.
  localparam logic ALIGN_CHK = 1'b0;
`endif

  logic misaligned;

  assign word_idx_o  = addr_i[ADDR_W+1:2];
  assign range_err_o = (addr_i[31:ADDR_W+2] != '0);
  assign misaligned  = (addr_i[1:0] != 2'b00);
  assign align_err_o = misaligned & ALIGN_CHK;

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequences one load/store at a time into a level-sensitive 32x32 RAM; WE pulses only while Dir/Datoin are stable.
// Latency accept->rsp_valid: store 4, load 2, error 1 cycles. Optional MEM_ALIGN_CHK_EN rejects misaligned addresses.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_dir,
  output logic [DATA_W-1:0] ram_datoin,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_datoout
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ram_dir_q, ram_dir_d;
  logic [DATA_W-1:0] ram_datoin_q, ram_datoin_d;
  logic              ram_we_q, ram_we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [ADDR_W-1:0] word_idx;
  logic              range_err;
  logic              align_err;
  logic              acc_err;
  logic              accept;

  ram_addr_chk #(
    .ADDR_W (ADDR_W)
  ) u_addr_chk (
    .addr_i      (req_addr),
    .word_idx_o  (word_idx),
    .range_err_o (range_err),
    .align_err_o (align_err)
  );

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign acc_err   = range_err | align_err;

  assign ram_dir    = ram_dir_q;
  assign ram_datoin = ram_datoin_q;
  assign ram_we     = ram_we_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

  // State and output registers; reset clears everything, dropping any WE pulse in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ram_dir_q    <= '0;
      ram_datoin_q <= '0;
      ram_we_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram_dir_q    <= ram_dir_d;
      ram_datoin_q <= ram_datoin_d;
      ram_we_q     <= ram_we_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Next state and next register values; Dir/Datoin only move on accept, WE is high only in W_PULSE.
  always_comb begin
    state_d      = state_q;
    ram_dir_d    = ram_dir_q;
    ram_datoin_d = ram_datoin_q;
    ram_we_d     = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          ram_dir_d = word_idx;
          if (acc_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (req_we) begin
            ram_datoin_d = req_wdata;
            state_d      = W_SETUP;
          end else begin
            state_d = R_ADDR;
          end
        end
      end
      W_SETUP: begin
        state_d  = W_PULSE;
        ram_we_d = 1'b1;
      end
      W_PULSE: begin
        state_d = W_HOLD;
      end
      W_HOLD: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      R_ADDR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ram_datoout;
        rsp_err_d   = 1'b0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: behavioural RAM, word-level reference memory, directed + random requests.
// Expected results follow from address rules (range, optional MEM_ALIGN_CHK_EN alignment) and fixed latencies.
// Responses are optionally stalled to check that outputs hold while rsp_ready is low.
module tb_ram_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [4:0]  ram_dir;
  logic [31:0] ram_datoin;
  logic        ram_we;
  logic [31:0] ram_datoout;

  logic        mem_clr;
  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];

  int n_vec;
  int n_err;

  ram_access_ctrl #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .ram_dir     (ram_dir),
    .ram_datoin  (ram_datoin),
    .ram_we      (ram_we),
    .ram_datoout (ram_datoout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: write while WE is high at a clock edge, asynchronous read.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else if (ram_we) begin
      mem[ram_dir] <= ram_datoin;
    end
  end
  assign ram_datoout = mem[ram_dir];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction, with the expected outcome derived from the address rules.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          lat;
    int          we_cnt;
    logic [4:0]  idx;

    idx     = addr[6:2];
    exp_err = (addr[31:7] != 25'd0);
`ifdef MEM_ALIGN_CHK_EN
    if (addr[1:0] != 2'b00) exp_err = 1'b1;
`endif
    exp_lat = exp_err ? 1 : (we ? 4 : 2);
    exp_rd  = (exp_err || we) ? 32'h0 : ref_mem[idx];
    if (!exp_err && we) ref_mem[idx] = wdata;

    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    // Garbage on the request bus while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    if (!exp_err) chk("ram_dir", {27'd0, ram_dir}, {27'd0, idx});
    if (!exp_err && we) chk("ram_datoin", ram_datoin, wdata);

    lat    = 1;
    we_cnt = 0;
    while (!rsp_valid && lat < 10) begin
      if (ram_we) we_cnt++;
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("we_pulses", 32'(we_cnt), (we && !exp_err) ? 32'd1 : 32'd0);
    if (!exp_err) chk("ram_dir_held", {27'd0, ram_dir}, {27'd0, idx});
    chk("ram_we_resp", {31'd0, ram_we}, 32'd0);
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});

    rsp_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      tick();
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", {31'd0, rsp_err}, {31'd0, exp_err});
    end

    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] v;
    logic        w;
    int          sel;

    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    mem_clr   = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

    // Reset held for three clocks.
    tick();
    tick();
    tick();
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_dir", {27'd0, ram_dir}, 32'd0);
    chk("rst_ram_datoin", ram_datoin, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n   = 1'b1;
    mem_clr = 1'b0;
    tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Store then load word 4, load stalled for five cycles.
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 32'h0000_0010, 32'h0, 0);
    do_req(1'b0, 32'h0000_0010, 32'h0, 5);

    // Out-of-range load and store.
    do_req(1'b0, 32'h0000_0080, 32'h0, 2);
    do_req(1'b1, 32'h8000_0000, 32'h1234_5678, 0);

    // Word 31 boundary round trip, then misaligned accesses.
    do_req(1'b1, 32'h0000_007C, 32'hA5A5_5A5A, 1);
    do_req(1'b0, 32'h0000_007C, 32'h0, 0);
    do_req(1'b0, 32'h0000_0013, 32'h0, 0);
    do_req(1'b1, 32'h0000_0002, 32'hCAFE_F00D, 0);
    do_req(1'b0, 32'h0000_0000, 32'h0, 0);

    // Reset during the write pulse; rewrite the value already held so the outcome is unambiguous.
    v         = ref_mem[9];
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0024;
    req_wdata = v;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pulse_ram_we", {31'd0, ram_we}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    do_req(1'b0, 32'h0000_0024, 32'h0, 0);

    // Randomised mix: in range, misaligned, out of range, with random stalls.
    for (int n = 0; n < 40; n++) begin
      w   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      a   = 32'($urandom_range(0, 31)) << 2;
      if (sel == 0) a = a | (32'd1 << $urandom_range(7, 31));
      if (sel == 1) a = a | 32'($urandom_range(1, 3));
      do_req(w, a, $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
